// File: rtl/div_op.sv
// div_op: multi-cycle signed restoring divider (radix-2, one trial subtraction per clock).
//
// Ports:
//   clock      - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   ctrl_div   - start pulse; a start in any state (re)launches with the new operands
//   dividend   - signed dividend, sampled with ctrl_div
//   divisor    - signed divisor, sampled with ctrl_div
//   quotient   - signed quotient, truncated toward zero (held until the next result)
//   remainder  - signed remainder, sign follows the dividend (held until the next result)
//   exception  - divide-by-zero or overflow flag for the current result
//   ready      - one-cycle pulse marking a new result
//   busy       - high while an operation is in flight
//
// Build option: define DIV_ZERO_FAST_EN to finish a zero-divisor operation one
// cycle after its start instead of running the full iteration count.
module div_op #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  localparam int unsigned PW = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] NEG_ONE  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;          // partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting into quotient bits
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;      // raw dividend, returned as remainder on divide-by-zero
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exc_q, exc_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [PW-1:0]    shifted;
  logic [PW-1:0]    trial;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  // Trial subtraction at WIDTH+1 bits: P may hold up to 2^WIDTH-1 after the shift.
  always_comb begin
    shifted = {p_q, q_q[WIDTH-1]};
    trial   = shifted + PW'({1'b1, ~dvs_q}) + PW'(1);
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;
    ready_d     = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
      end
      RUN: begin
        // Restore on borrow: keep the shifted value when the trial went negative.
        p_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (div0_q) begin
          quotient_d  = '0;
          remainder_d = dvd_q;
        end else begin
          // Overflow needs no special value: -(2^(WIDTH-1)) wraps to MIN_VAL.
          quotient_d  = neg_quo_q ? negate(q_q) : q_q;
          remainder_d = neg_rem_q ? negate(p_q) : p_q;
        end
        exc_d   = div0_q | ovf_q;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start overrides the iteration in any state; a finishing result still goes out.
    if (ctrl_div) begin
      dvd_d     = dividend;
      q_d       = abs_val(dividend);
      dvs_d     = abs_val(divisor);
      p_d       = '0;
      cnt_d     = '0;
      neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_d = dividend[WIDTH-1];
      div0_d    = (divisor == '0);
      ovf_d     = (dividend == MIN_VAL) && (divisor == NEG_ONE);
      busy_d    = 1'b1;
`ifdef DIV_ZERO_FAST_EN
      state_d   = (divisor == '0) ? DONE : RUN;
`else
      state_d   = RUN;
`endif
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign exception = exc_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_div_op.sv
// tb_div_op: directed scoreboard bench for div_op (signed divide, latency, abort, reset).
module tb_div_op;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         ctrl_div;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         exception;
  logic         ready;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         exc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  div_op #(.WIDTH(32), .CNT_W(6)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ctrl_div  (ctrl_div),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .exception (exception),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: language signed division plus the two exceptional operand pairs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '0; e.r = a; e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = '0; e.exc = 1'b1;
    end else begin
      e.q = W'($signed(a) / $signed(b));
      e.r = W'($signed(a) % $signed(b));
      e.exc = 1'b0;
    end
    return e;
  endfunction

  function automatic int lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == '0) return 1;
`endif
    return 33;
  endfunction

  // Start edge is the posedge inside this task; returns 1 time unit after it.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    ctrl_div = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({tag, " quotient"},  quotient,  x.q);
      check({tag, " remainder"}, remainder, x.r);
      check({tag, " exception"}, W'(exception), W'(x.exc));
    end
  endtask

  // Waits (bounded) for ready, counting edges after the start edge.
  task automatic wait_ready(input string tag, input int exp_lat);
    int e       = 0;
    bit seen    = 1'b0;
    bit busy_ok = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clock);
      #1;
      if (ready === 1'b1) begin
        e    = i;
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, " latency"}, W'(e), W'(exp_lat));
    check({tag, " busy while running"}, W'(busy_ok), 32'd1);
    if (seen) begin
      check({tag, " busy at ready"}, W'(busy), 32'd0);
      pop_check(tag);
      @(posedge clock);
      #1;
      check({tag, " ready pulse width"}, W'(ready), 32'd0);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(a, b));
    start(a, b);
    wait_ready(tag, lat(b));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           quiet;

    reset_n  = 1'b0;
    ctrl_div = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset quotient",  quotient,  32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset exception", W'(exception), 32'd0);
    check("reset ready",     W'(ready),     32'd0);
    check("reset busy",      W'(busy),      32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_op("100/7",     32'd100,        32'd7);
    run_op("-100/7",    W'(-100),       32'd7);
    run_op("100/-7",    32'd100,        W'(-7));
    run_op("-100/-7",   W'(-100),       W'(-7));
    run_op("min/-1",    32'h8000_0000,  32'hFFFF_FFFF);
    run_op("min/1",     32'h8000_0000,  32'd1);
    run_op("55/0",      32'd55,         32'd0);
    run_op("-9/0",      W'(-9),         32'd0);
    run_op("3/100",     32'd3,          32'd100);
    run_op("min/min",   32'h8000_0000,  32'h8000_0000);
    run_op("maxp/min",  32'h7FFF_FFFF,  32'h8000_0000);

    for (int k = 0; k < 4; k++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(1, 5000));
      if (k[0]) rb = W'(-rb);
      run_op($sformatf("random%0d", k), ra, rb);
    end

    // Start in the finishing cycle: first result delivered, second launched.
    sb.push_back(model(32'd200, 32'd9));
    start(32'd200, 32'd9);
    repeat (32) begin
      @(posedge clock);
      #1;
    end
    sb.push_back(model(W'(-77), 32'd5));
    start(W'(-77), 32'd5);
    check("overlap ready", W'(ready), 32'd1);
    pop_check("overlap first");
    check("overlap busy", W'(busy), 32'd1);
    wait_ready("overlap second", 33);

    // Restart mid-operation: only the second start produces a result.
    sb.push_back(model(32'd9, 32'd3));
    start(32'd100, 32'd7);
    quiet = 1'b1;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (ready !== 1'b0) quiet = 1'b0;
    end
    check("abort no early ready", W'(quiet), 32'd1);
    start(32'd9, 32'd3);
    wait_ready("abort restart", 33);

    // Reset mid-operation; previous results must hold until then.
    start(32'd100, 32'd7);
    check("hold quotient after start", quotient, 32'd3);
    repeat (14) begin
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset quotient",  quotient,  32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset exception", W'(exception), 32'd0);
    check("midreset ready",     W'(ready),     32'd0);
    check("midreset busy",      W'(busy),      32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (ready !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("post-reset idle", W'(quiet), 32'd1);
    run_op("81/9", 32'd81, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
